// File: rtl/rain_pkg.sv
// ============================================================================
// rain_pkg : shared constants, spawn record type and LFSR step function
// Rev 1.0
// ============================================================================
`default_nettype none

package rain_pkg;

  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam int          NUM_COLS    = 53;
  localparam int          COL_PITCH   = 12;
  localparam logic [7:0]  LETTER_BASE = 8'h61;
  localparam int          NUM_LETTERS = 26;

  typedef struct packed {
    logic [7:0] ch;
    logic [3:0] speed;
    logic [8:0] x;
    logic [9:0] y;
  } spawn_t;

  // Right-shifting Galois step: feed the outgoing bit back through the mask.
  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return (r >> 1) ^ (r[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr32.sv
// ============================================================================
// lfsr32 : 32-bit Galois LFSR, seed loaded on reset, advances when enabled
// Rev 1.0
// ============================================================================
`default_nettype none

module lfsr32
  import rain_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] q,
  output logic [31:0] next
);

  // An all-zero state would lock up the register forever.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] r_q;
  logic [31:0] r_d;

  assign r_d  = lfsr_step(r_q);
  assign q    = r_q;
  assign next = r_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= SEED_EFF;
    end else if (en) begin
      r_q <= r_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rain_char_generator.sv
// ============================================================================
// rain_char_generator : spawns one random falling letter per enabled clock
// Rev 1.0
// ============================================================================
`default_nettype none

module rain_char_generator
  import rain_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] ch,
  output logic [3:0] speed,
  output logic [8:0] x,
  output logic [9:0] y,
  output logic       valid
);

  localparam logic [4:0] C_LETTERS  = 5'(NUM_LETTERS);
  localparam logic [5:0] C_COLS     = 6'(NUM_COLS);
  localparam logic [5:0] C_LAST_COL = 6'(NUM_COLS - 1);

  logic [31:0] w_r_q;
  logic [31:0] w_n;
  logic        w_unused_q;

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .q    (w_r_q),
    .next (w_n)
  );

  assign w_unused_q = ^w_r_q;

  logic [20:0] w_lprod;
  logic [4:0]  w_li;
  logic [11:0] w_kprod;
  logic [5:0]  w_k0;
  logic [5:0]  w_k;
  spawn_t      w_spawn_d;
  spawn_t      r_spawn_q;
  logic [5:0]  r_last_k_q;
  logic        r_valid_q;

  // Scale 16-bit and 6-bit random fields onto their ranges without division.
  assign w_lprod = 21'(w_n[15:0]) * 21'(C_LETTERS);
  assign w_li    = 5'(w_lprod >> 16);
  assign w_kprod = 12'(w_n[31:26]) * 12'(C_COLS);
  assign w_k0    = 6'(w_kprod >> 6);

  always_comb begin
    w_k = w_k0;
    if (w_k0 == r_last_k_q) begin
      w_k = (w_k0 == C_LAST_COL) ? 6'd0 : w_k0 + 6'd1;
    end
  end

  // k*12 = k*8 + k*4
  assign w_spawn_d.ch    = LETTER_BASE + {3'b000, w_li};
  assign w_spawn_d.speed = (w_n[19:16] == 4'd0) ? 4'd1 : w_n[19:16];
  assign w_spawn_d.x     = {3'b000, w_n[25:20]};
  assign w_spawn_d.y     = {1'b0, w_k, 3'b000} + {2'b00, w_k, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spawn_q  <= '0;
      r_last_k_q <= 6'd63;
      r_valid_q  <= 1'b0;
    end else begin
      r_valid_q <= en;
      if (en) begin
        r_spawn_q  <= w_spawn_d;
        r_last_k_q <= w_k;
      end
    end
  end

  assign ch    = r_spawn_q.ch;
  assign speed = r_spawn_q.speed;
  assign x     = r_spawn_q.x;
  assign y     = r_spawn_q.y;
  assign valid = r_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rain_char_generator.sv
// ============================================================================
// tb_rain_char_generator : directed and random checks of the letter spawner
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rain_char_generator;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic [7:0] ch1, ch2, ch3;
  logic [3:0] sp1, sp2, sp3;
  logic [8:0] x1, x2, x3;
  logic [9:0] y1, y2, y3;
  logic       v1, v2, v3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rain_char_generator #(.SEED(32'h0000_0001)) dut1 (
    .clk(clk), .rst(rst), .en(en),
    .ch(ch1), .speed(sp1), .x(x1), .y(y1), .valid(v1)
  );

  // Seed chosen so the first two spawns both land on the last column.
  rain_char_generator #(.SEED(32'hF840_0005)) dut2 (
    .clk(clk), .rst(rst), .en(en),
    .ch(ch2), .speed(sp2), .x(x2), .y(y2), .valid(v2)
  );

  rain_char_generator #(.SEED(32'h0000_0000)) dut3 (
    .clk(clk), .rst(rst), .en(en),
    .ch(ch3), .speed(sp3), .x(x3), .y(y3), .valid(v3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [25:0] let_seen;
  logic [52:0] col_seen;
  logic [9:0]  prev_y;
  logic [7:0]  prev_ch;
  int          range_bad;
  int          repeat_bad;
  int          hold_bad;
  int          valid_bad;
  logic        en_prev;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) tick();

    check_eq("rst_ch",    {24'd0, ch1}, 32'd0);
    check_eq("rst_speed", {28'd0, sp1}, 32'd0);
    check_eq("rst_x",     {23'd0, x1},  32'd0);
    check_eq("rst_y",     {22'd0, y1},  32'd0);
    check_eq("rst_valid", {31'd0, v1},  32'd0);

    rst = 1'b0;
    repeat (10) tick();
    check_eq("idle_ch",    {24'd0, ch1}, 32'd0);
    check_eq("idle_y",     {22'd0, y1},  32'd0);
    check_eq("idle_valid", {31'd0, v1},  32'd0);

    // Spawn 1: n = 8020_0003
    en = 1'b1;
    tick();
    check_eq("s1_ch",    {24'd0, ch1}, 32'h61);
    check_eq("s1_speed", {28'd0, sp1}, 32'd1);
    check_eq("s1_x",     {23'd0, x1},  32'd2);
    check_eq("s1_y",     {22'd0, y1},  32'd312);
    check_eq("s1_valid", {31'd0, v1},  32'd1);
    check_eq("seed0_y",  {22'd0, y3},  32'd312);
    check_eq("col52_y",  {22'd0, y2},  32'd624);
    check_eq("col52_x",  {23'd0, x2},  32'd0);

    // Spawn 2: n = C030_0002; dut2 collides on column 52 and wraps
    tick();
    check_eq("s2_ch",    {24'd0, ch1}, 32'h61);
    check_eq("s2_speed", {28'd0, sp1}, 32'd1);
    check_eq("s2_x",     {23'd0, x1},  32'd3);
    check_eq("s2_y",     {22'd0, y1},  32'd468);
    check_eq("s2_valid", {31'd0, v1},  32'd1);
    check_eq("wrap_y",      {22'd0, y2}, 32'd0);
    check_eq("wrap_x",      {23'd0, x2}, 32'd34);
    check_eq("wrap_last_k", {26'd0, dut2.r_last_k_q}, 32'd0);

    // Spawn 3: n = 6018_0001
    tick();
    check_eq("s3_ch",    {24'd0, ch1}, 32'h61);
    check_eq("s3_speed", {28'd0, sp1}, 32'd8);
    check_eq("s3_x",     {23'd0, x1},  32'd1);
    check_eq("s3_y",     {22'd0, y1},  32'd228);

    en = 1'b0;
    tick();
    check_eq("pulse_valid", {31'd0, v1},  32'd0);
    check_eq("hold_y",      {22'd0, y1},  32'd228);
    check_eq("hold_speed",  {28'd0, sp1}, 32'd8);

    let_seen   = '0;
    col_seen   = '0;
    prev_y     = 10'd228;
    prev_ch    = 8'h61;
    range_bad  = 0;
    repeat_bad = 0;
    hold_bad   = 0;
    valid_bad  = 0;
    for (int i = 0; i < 10000; i++) begin
      en_prev = (($urandom % 4) != 0);
      en = en_prev;
      tick();
      if (v1 !== en_prev) valid_bad++;
      if (en_prev) begin
        if (ch1 < 8'h61 || ch1 > 8'h7A) range_bad++;
        if (sp1 < 4'd1) range_bad++;
        if (x1 > 9'd63) range_bad++;
        if ((y1 % 12) != 0 || y1 > 10'd624) range_bad++;
        if (y1 == prev_y) repeat_bad++;
        if (ch1 >= 8'h61 && ch1 <= 8'h7A) let_seen[ch1 - 8'h61] = 1'b1;
        if ((y1 % 12) == 0 && y1 <= 10'd624) col_seen[y1 / 12] = 1'b1;
      end else begin
        if (y1 !== prev_y || ch1 !== prev_ch) hold_bad++;
      end
      prev_y  = y1;
      prev_ch = ch1;
    end
    check_eq("rand_range",   range_bad,  32'd0);
    check_eq("rand_repeat",  repeat_bad, 32'd0);
    check_eq("rand_hold",    hold_bad,   32'd0);
    check_eq("rand_valid",   valid_bad,  32'd0);
    check_eq("cov_letters",  {6'd0, let_seen}, 32'h03FF_FFFF);
    check_eq("cov_cols_lo",  col_seen[31:0],   32'hFFFF_FFFF);
    check_eq("cov_cols_hi",  {11'd0, col_seen[52:32]}, 32'h001F_FFFF);

    // Reset wins over a simultaneous spawn request
    en  = 1'b1;
    tick();
    rst = 1'b1;
    en  = 1'b1;
    tick();
    check_eq("rst_en_ch",    {24'd0, ch1}, 32'd0);
    check_eq("rst_en_y",     {22'd0, y1},  32'd0);
    check_eq("rst_en_valid", {31'd0, v1},  32'd0);

    rst = 1'b0;
    tick();
    check_eq("restart_ch",    {24'd0, ch1}, 32'h61);
    check_eq("restart_speed", {28'd0, sp1}, 32'd1);
    check_eq("restart_x",     {23'd0, x1},  32'd2);
    check_eq("restart_y",     {22'd0, y1},  32'd312);
    check_eq("restart_valid", {31'd0, v1},  32'd1);

    en = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rain_char_generator.md
# rain_char_generator

Pseudo-random character spawner for the falling-letters typing game. On each enabled clock it produces one new falling character: lowercase ASCII code, fall speed, starting vertical offset and screen column. Its outputs feed the character display RAM (`ascii_ram`, written at address `y` with data `ch`) and the per-column offset/speed tables. The rendered glyph comes from `Lattice_ROM`, which is 12 pixels wide by 16 rows.

## Interface
Parameters:
- `SEED`, default 32'h0000_0001: LFSR reset value. A value of 0 is illegal and is replaced by 32'h1.

Ports:
- `clk` in 1: spawn clock. All logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: spawn request. When high, one new character is generated this cycle.
- `ch` out 8: ASCII code, 8'h61..8'h7A.
- `speed` out 4: fall speed in pixels per move tick, 1..15.
- `x` out 9: initial vertical offset (row), 0..63.
- `y` out 10: column pixel address, always a multiple of 12, 0..624.
- `valid` out 1: one-cycle pulse marking a new character on the outputs.

## Operation
- State:
  - `r`: 32-bit Galois LFSR, right-shifting, mask 32'h8020_0003.
  - `last_k`: 6 bits, index of the previously used column.
- LFSR step: `step(r) = (r >> 1) ^ (r[0] ? MASK : 0)`.
- On a cycle with `en`=1, compute `n = step(r)` and register `r <= n`. All output fields are derived from `n`.
- Output fields:
  - Letter index `li = (n[15:0] * 26) >> 16`, range 0..25. `ch = 8'h61 + li`.
  - `speed = (n[19:16] == 0) ? 1 : n[19:16]`.
  - `x = {3'b0, n[25:20]}`.
  - Column index `k0 = (n[31:26] * 53) >> 6`, range 0..52.
  - If `k0 == last_k`, then `k = (k0 == 52) ? 0 : k0 + 1`; otherwise `k = k0`.
  - `y = k * 12`, done with a shift-add, no multiplier required. `last_k <= k`.
- `valid <= en`.
- With `en`=0, `r`, `last_k` and all data outputs hold their values.
- Arithmetic:
  - The 16×5-bit product must be 21 bits wide.
  - The 6×6-bit product must be 12 bits wide.
  - `y` must be computed at 10 bits with no truncation.

## Timing
- Latency is one cycle: fields for the `en` asserted at edge t appear after edge t and persist until the next enabled edge.
- Back-to-back `en` produces a new character every cycle.
- Reset values: `r = SEED` (or 1 if SEED is 0), `last_k = 63`, `ch = 0`, `speed = 0`, `x = 0`, `y = 0`, `valid = 0`.
- `rst` and `en` high in the same cycle: reset wins and no character is produced.
- Reset mid-stream restarts the sequence exactly from SEED.
- Outputs are registered; there is no combinational path from `en` to the outputs.

## Structure
- Shared package `rain_pkg` holds:
  - `LFSR_MASK` = 32'h8020_0003
  - `NUM_COLS` = 53
  - `COL_PITCH` = 12
  - `LETTER_BASE` = 8'h61
  - `NUM_LETTERS` = 26
- Sub-module `lfsr32`: implements the step function with a load-on-reset seed. Ports are `clk`, `rst`, `en` and `q`, plus a combinational `next` output.
- The top level contains the field mapping, the column-collision logic and the output registers.

## Test plan
- Reset with SEED=1: all outputs are 0, `valid`=0. Holding `en`=0 for 10 cycles changes nothing.
- First `en` after reset, SEED=1: `n` = 32'h8020_0003. Required outputs: `ch`=8'h61, `speed`=1, `x`=2, `y`=312 (k=26), `valid`=1 for exactly one cycle.
- Second consecutive `en`: `n` = 32'hC030_0002. Required outputs: `ch`=8'h61, `speed`=1, `x`=3, `y`=468 (k=39).
- 10,000 random `en` cycles must satisfy every invariant:
  - `ch` in 8'h61..8'h7A and `speed` in 1..15.
  - `x` ≤ 63.
  - `y` mod 12 = 0 and `y` ≤ 624.
  - No two consecutive spawns share the same `y`.
  - Every letter and every column appears at least once.
- Collision wrap: force `last_k`=52 and a state whose `n[31:26]` maps to `k0`=52. Required: `y`=0 and `last_k` becomes 0.
- `rst` asserted together with `en` mid-stream: outputs go to reset values. The following `en` reproduces the first-spawn values above.
